scr1_dmem_arb: RTL and testbench
================================

// Module: scr1_dmem_arb
// PURPOSE
//  Shares the single DMEM port between the LSU (port 0) and the vector DMA engine (port 1).
//  Round-robin grant; grant held until req_ack; an owner FIFO routes each response to its issuer.
//  Sits between pipeline/VDMA and the DMEM router; uses the scr1_memif request/ack/response protocol.
// PARAMETERS
//  OUTST_DEPTH  2     max accepted-but-unanswered transactions (1..4)
//  LSU_PRIO     1'b0  1: port 0 always wins when both request; 0: round-robin
// PORTS
//  clk                 in   1                       core clock
//  rst                 in   1                       synchronous, active-high reset
//  lsu2arb_req         in   1                       port 0 request
//  lsu2arb_cmd         in   type_scr1_mem_cmd_e     port 0 RD/WR
//  lsu2arb_width       in   type_scr1_mem_width_e   port 0 BYTE/HWORD/WORD/VECTOR
//  lsu2arb_addr        in   SCR1_DMEM_AWIDTH        port 0 address
//  lsu2arb_wdata       in   type_vector             port 0 store data
//  arb2lsu_req_ack     out  1                       port 0 request accepted
//  arb2lsu_rdata       out  type_vector             port 0 load data
//  arb2lsu_resp        out  type_scr1_mem_resp_e    port 0 response
//  vdma2arb_*          in   (as lsu2arb_*)          port 1 request group
//  arb2vdma_*          out  (as arb2lsu_*)          port 1 ack/rdata/resp group
//  arb2dmem_req/cmd/width/addr/wdata  out  (as above)  muxed request to DMEM
//  dmem2arb_req_ack    in   1                       DMEM accepted request
//  dmem2arb_rdata      in   type_vector             DMEM load data
//  dmem2arb_resp       in   type_scr1_mem_resp_e    DMEM response
//  arb_busy            out  1                       owner FIFO non-empty
//  arb_err             out  1                       sticky: response with no outstanding txn
// BEHAVIOUR
//  Reset: FIFO empty, rr_ptr=0 (port 0 next), state ARB_FREE, arb_err=0; all outputs 0 / RESP_NOTRDY.
//  FSM: ARB_FREE -> ARB_HOLD when arb2dmem_req & ~dmem2arb_req_ack; HOLD -> FREE on ack.
//   FREE: winner picked combinationally (LSU_PRIO, else rr_ptr); HOLD: grant frozen to latched owner.
//  arb2dmem_req = granted port's req & ~fifo_full; cmd/width/addr/wdata muxed from granted port.
//  Ungranted port's req must not be forwarded (it must hold req stable until its own ack).
//  req_ack routed combinationally to granted port only (0-cycle, same as DMEM ack).
//  On arb2dmem_req & ack: push owner id; rr_ptr <= ~owner (round-robin mode).
//  Response: dmem2arb_resp != NOTRDY pops FIFO head; resp+rdata go to head owner,
//   other port sees RESP_NOTRDY and rdata='0. Pop and push may happen in the same cycle.
//  Full: fifo_full blocks forwarding even if a pop happens that cycle (no pass-through).
//  Response with FIFO empty: dropped (both ports NOTRDY), arb_err <= 1 until rst.
//  rst mid-transaction: FIFO flushed; late responses then hit the empty rule and set arb_err.
//  Request->resp latency adds 0 cycles; only queueing delay from arbitration/full.
// STRUCTURE
//  Add type_scr1_dmem_arb_owner_e {SCR1_ARB_LSU, SCR1_ARB_VDMA} and the FSM enum to scr1_memif.svh.
//  Sub-module scr1_arb_owner_fifo: OUTST_DEPTH x 1-bit FIFO, wrap-around ptrs, full/empty, sync rst.
//  Top: arbitration FSM, rr_ptr, muxes, response demux, arb_err.
// TESTING
//  LSU LW addr 0x100, DMEM ack same cycle, RDY_OK next -> LSU gets ack then resp; VDMA NOTRDY.
//  Both req same cycle, LSU_PRIO=0, rr_ptr=0 -> LSU granted, then VDMA on next ack; alternates.
//  VDMA SV req, DMEM withholds ack 3 cycles while LSU raises req -> grant stays VDMA, addr stable.
//  OUTST_DEPTH=2, two acked reqs, no resp -> 3rd req not forwarded; resp pops -> 3rd forwarded next cycle.
//  Responses RDY_ER (LSU) then RDY_OK (VDMA) -> routed in issue order; rdata to correct port.
//  Assert rst with 1 txn pending, then DMEM gives RDY_OK -> both ports NOTRDY, arb_err=1.

Source files
------------

// File: rtl/scr1_dmem_arb_pkg.sv
// Shared types for the DMEM arbiter slice: memory-interface enums, vector data type,
// owner id and arbitration FSM encoding.
package scr1_dmem_arb_pkg;

    localparam int SCR1_DMEM_AWIDTH  = 32;
    localparam int SCR1_VECTOR_WIDTH = 64;

    typedef logic [SCR1_VECTOR_WIDTH-1:0] type_vector;

    typedef enum logic {
        SCR1_MEM_CMD_RD = 1'b0,
        SCR1_MEM_CMD_WR = 1'b1
    } type_scr1_mem_cmd_e;

    typedef enum logic [1:0] {
        SCR1_MEM_WIDTH_BYTE   = 2'b00,
        SCR1_MEM_WIDTH_HWORD  = 2'b01,
        SCR1_MEM_WIDTH_WORD   = 2'b10,
        SCR1_MEM_WIDTH_VECTOR = 2'b11
    } type_scr1_mem_width_e;

    typedef enum logic [1:0] {
        SCR1_MEM_RESP_NOTRDY = 2'b00,
        SCR1_MEM_RESP_RDY_OK = 2'b01,
        SCR1_MEM_RESP_RDY_ER = 2'b10
    } type_scr1_mem_resp_e;

    typedef enum logic {
        SCR1_ARB_LSU  = 1'b0,
        SCR1_ARB_VDMA = 1'b1
    } type_scr1_dmem_arb_owner_e;

    typedef enum logic {
        ARB_FREE = 1'b0,
        ARB_HOLD = 1'b1
    } type_scr1_dmem_arb_state_e;

    function automatic type_scr1_dmem_arb_owner_e scr1_arb_other(
        input type_scr1_dmem_arb_owner_e owner
    );
        return (owner == SCR1_ARB_LSU) ? SCR1_ARB_VDMA : SCR1_ARB_LSU;
    endfunction

endpackage : scr1_dmem_arb_pkg

// File: rtl/scr1_dmem_arb_if.sv
// scr1_memif request/ack/response bundle; master issues requests, slave acknowledges and responds.
interface scr1_dmem_arb_if;
    import scr1_dmem_arb_pkg::*;

    // A request is accepted in the cycle where req & req_ack are both high; the master holds
    // req and its cmd/width/addr/wdata stable until then. A response is any cycle with
    // resp != NOTRDY and is returned in the order requests were accepted.
    logic                 req;
    type_scr1_mem_cmd_e   cmd;
    type_scr1_mem_width_e width;
    logic [SCR1_DMEM_AWIDTH-1:0] addr;
    type_vector           wdata;
    logic                 req_ack;
    type_vector           rdata;
    type_scr1_mem_resp_e  resp;

    modport master (
        output req, cmd, width, addr, wdata,
        input  req_ack, rdata, resp
    );

    modport slave (
        input  req, cmd, width, addr, wdata,
        output req_ack, rdata, resp
    );

endinterface : scr1_dmem_arb_if

// File: rtl/scr1_arb_owner_fifo.sv
// Owner FIFO: remembers which port issued each accepted DMEM transaction so responses
// can be returned to it in order.
module scr1_arb_owner_fifo
    import scr1_dmem_arb_pkg::*;
#(
    parameter int DEPTH = 2
) (
    input  logic                      clk,
    input  logic                      rst,
    input  logic                      push,
    input  type_scr1_dmem_arb_owner_e push_owner,
    input  logic                      pop,
    output type_scr1_dmem_arb_owner_e head_owner,
    output logic                      full,
    output logic                      empty
);

    localparam int PW = (DEPTH > 1) ? $clog2(DEPTH) : 1;
    localparam int CW = $clog2(DEPTH + 1);
    localparam logic [PW-1:0] LAST = PW'(DEPTH - 1);

    type_scr1_dmem_arb_owner_e mem [DEPTH];
    logic [PW-1:0] wr_ptr;
    logic [PW-1:0] rd_ptr;
    logic [CW-1:0] count;
    logic          do_push;
    logic          do_pop;

    assign do_push = push & ~full;
    assign do_pop  = pop & ~empty;

    // Pointers wrap explicitly so non-power-of-two depths behave correctly.
    always_ff @(posedge clk) begin
        if (rst) begin
            wr_ptr <= '0;
            rd_ptr <= '0;
            count  <= '0;
            for (int i = 0; i < DEPTH; i++) begin
                mem[i] <= SCR1_ARB_LSU;
            end
        end else begin
            if (do_push) begin
                mem[wr_ptr] <= push_owner;
                wr_ptr      <= (wr_ptr == LAST) ? '0 : wr_ptr + 1'b1;
            end
            if (do_pop) begin
                rd_ptr <= (rd_ptr == LAST) ? '0 : rd_ptr + 1'b1;
            end
            case ({do_push, do_pop})
                2'b10:   count <= count + 1'b1;
                2'b01:   count <= count - 1'b1;
                default: count <= count;
            endcase
        end
    end

    assign full       = (count == CW'(DEPTH));
    assign empty      = (count == '0);
    assign head_owner = mem[rd_ptr];

endmodule : scr1_arb_owner_fifo

// File: rtl/scr1_dmem_arb.sv
// Two-port DMEM arbiter (LSU / vector DMA): round-robin or LSU-priority grant held until
// acknowledged, with an owner FIFO steering each response back to the issuing port.
module scr1_dmem_arb
    import scr1_dmem_arb_pkg::*;
#(
    parameter int OUTST_DEPTH = 2,
    parameter bit LSU_PRIO    = 1'b0
) (
    input  logic                      clk,
    input  logic                      rst,
    scr1_dmem_arb_if.slave            lsu,
    scr1_dmem_arb_if.slave            vdma,
    scr1_dmem_arb_if.master           dmem,
    output logic                      arb_busy,
    output logic                      arb_err,
    output type_scr1_dmem_arb_state_e arb_state
);

    type_scr1_dmem_arb_state_e state;
    type_scr1_dmem_arb_owner_e hold_owner;
    type_scr1_dmem_arb_owner_e rr_ptr;
    type_scr1_dmem_arb_owner_e winner;
    type_scr1_dmem_arb_owner_e grant;
    type_scr1_dmem_arb_owner_e head_owner;
    logic fifo_full;
    logic fifo_empty;
    logic gnt_req;
    logic push;
    logic pop;
    logic resp_vld;
    logic lsu_gnt;

    // Contention is resolved by fixed LSU priority or by rr_ptr; a lone requester always wins.
    always_comb begin
        winner = SCR1_ARB_LSU;
        if (lsu.req && vdma.req) begin
            winner = LSU_PRIO ? SCR1_ARB_LSU : rr_ptr;
        end else if (vdma.req) begin
            winner = SCR1_ARB_VDMA;
        end
    end

    assign grant   = (state == ARB_HOLD) ? hold_owner : winner;
    assign lsu_gnt = (grant == SCR1_ARB_LSU);
    assign gnt_req = lsu_gnt ? lsu.req : vdma.req;

    // No pass-through when full: a same-cycle pop does not free a slot for forwarding.
    assign dmem.req   = gnt_req & ~fifo_full;
    assign dmem.cmd   = lsu_gnt ? lsu.cmd   : vdma.cmd;
    assign dmem.width = lsu_gnt ? lsu.width : vdma.width;
    assign dmem.addr  = lsu_gnt ? lsu.addr  : vdma.addr;
    assign dmem.wdata = lsu_gnt ? lsu.wdata : vdma.wdata;

    assign push         = dmem.req & dmem.req_ack;
    assign lsu.req_ack  = push &  lsu_gnt;
    assign vdma.req_ack = push & ~lsu_gnt;

    assign resp_vld = (dmem.resp != SCR1_MEM_RESP_NOTRDY);
    assign pop      = resp_vld & ~fifo_empty;

    always_comb begin
        lsu.resp   = SCR1_MEM_RESP_NOTRDY;
        lsu.rdata  = '0;
        vdma.resp  = SCR1_MEM_RESP_NOTRDY;
        vdma.rdata = '0;
        if (pop) begin
            if (head_owner == SCR1_ARB_LSU) begin
                lsu.resp  = dmem.resp;
                lsu.rdata = dmem.rdata;
            end else begin
                vdma.resp  = dmem.resp;
                vdma.rdata = dmem.rdata;
            end
        end
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            state      <= ARB_FREE;
            hold_owner <= SCR1_ARB_LSU;
            rr_ptr     <= SCR1_ARB_LSU;
            arb_err    <= 1'b0;
        end else begin
            case (state)
                ARB_FREE: begin
                    if (dmem.req && !dmem.req_ack) begin
                        state      <= ARB_HOLD;
                        hold_owner <= grant;
                    end
                end
                ARB_HOLD: begin
                    if (push) begin
                        state <= ARB_FREE;
                    end
                end
                default: state <= ARB_FREE;
            endcase
            if (push && !LSU_PRIO) begin
                rr_ptr <= scr1_arb_other(grant);
            end
            // A response with nothing outstanding is dropped and flagged until reset.
            if (resp_vld && fifo_empty) begin
                arb_err <= 1'b1;
            end
        end
    end

    scr1_arb_owner_fifo #(
        .DEPTH (OUTST_DEPTH)
    ) i_owner_fifo (
        .clk        (clk),
        .rst        (rst),
        .push       (push),
        .push_owner (grant),
        .pop        (pop),
        .head_owner (head_owner),
        .full       (fifo_full),
        .empty      (fifo_empty)
    );

    assign arb_busy  = ~fifo_empty;
    assign arb_state = state;

endmodule : scr1_dmem_arb

// File: tb/tb_scr1_dmem_arb.sv
// Bench for scr1_dmem_arb: directed scenarios then random traffic, every cycle checked
// against a queue-based model of the arbitration and response-ordering rules.
module tb_scr1_dmem_arb;
  import scr1_dmem_arb_pkg::*;

  localparam int DEPTH = 2;

  typedef struct {
    logic                 req;
    type_scr1_mem_cmd_e   cmd;
    type_scr1_mem_width_e width;
    logic [31:0]          addr;
    logic [63:0]          wdata;
  } port_req_t;

  // ---------------- clock / reset ----------------
  logic clk = 1'b0;
  logic rst;
  always #5 clk = ~clk;

  scr1_dmem_arb_if lsu_if ();
  scr1_dmem_arb_if vdma_if ();
  scr1_dmem_arb_if dmem_if ();
  logic arb_busy;
  logic arb_err;
  type_scr1_dmem_arb_state_e arb_state;

  scr1_dmem_arb #(
    .OUTST_DEPTH (DEPTH),
    .LSU_PRIO    (1'b0)
  ) dut (
    .clk       (clk),
    .rst       (rst),
    .lsu       (lsu_if),
    .vdma      (vdma_if),
    .dmem      (dmem_if),
    .arb_busy  (arb_busy),
    .arb_err   (arb_err),
    .arb_state (arb_state)
  );

  // ---------------- reference model state ----------------
  logic [0:0] exp_q[$];   // owners of accepted, unanswered transactions (0=LSU, 1=VDMA)
  bit         m_locked;
  logic [0:0] m_held;
  logic [0:0] m_rr;
  bit         m_err;
  port_req_t  p[2];
  int n_cmp;
  int n_fail;

  task automatic chk(input string tag, input logic [63:0] obs, input logic [63:0] exp);
    n_cmp++;
    assert (obs === exp) else begin
      n_fail++;
      $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
    end
  endtask

  task automatic model_reset();
    exp_q.delete();
    m_locked = 0;
    m_held   = 1'b0;
    m_rr     = 1'b0;
    m_err    = 0;
  endtask

  // ---------------- driver tasks ----------------
  task automatic drive_ports();
    lsu_if.req    = p[0].req;
    lsu_if.cmd    = p[0].cmd;
    lsu_if.width  = p[0].width;
    lsu_if.addr   = p[0].addr;
    lsu_if.wdata  = p[0].wdata;
    vdma_if.req   = p[1].req;
    vdma_if.cmd   = p[1].cmd;
    vdma_if.width = p[1].width;
    vdma_if.addr  = p[1].addr;
    vdma_if.wdata = p[1].wdata;
  endtask

  task automatic set_req(input int i, input type_scr1_mem_cmd_e c, input type_scr1_mem_width_e w,
                         input logic [31:0] a, input logic [63:0] d);
    p[i].req   = 1'b1;
    p[i].cmd   = c;
    p[i].width = w;
    p[i].addr  = a;
    p[i].wdata = d;
  endtask

  task automatic set_rand_req(input int i);
    set_req(i, type_scr1_mem_cmd_e'($urandom_range(0, 1)),
            type_scr1_mem_width_e'($urandom_range(0, 3)),
            $urandom, {$urandom, $urandom});
  endtask

  task automatic do_reset(input int cycles);
    rst = 1'b1;
    for (int i = 0; i < 2; i++) begin
      p[i].req = 1'b0; p[i].cmd = SCR1_MEM_CMD_RD; p[i].width = SCR1_MEM_WIDTH_BYTE;
      p[i].addr = '0; p[i].wdata = '0;
    end
    drive_ports();
    dmem_if.req_ack = 1'b0;
    dmem_if.resp    = SCR1_MEM_RESP_NOTRDY;
    dmem_if.rdata   = '0;
    repeat (cycles) @(posedge clk);
    #1 rst = 1'b0;
    model_reset();
  endtask

  // One clock cycle: apply inputs, compare every output with the model at the negedge,
  // then advance the model and drop requests that were accepted.
  task automatic step(input logic ack, input type_scr1_mem_resp_e resp, input logic [63:0] rdata);
    logic [0:0] g;
    logic [0:0] o;
    bit full;
    bit fwd;
    type_scr1_mem_resp_e exp_resp[2];
    logic [63:0] exp_rd[2];
    drive_ports();
    dmem_if.req_ack = ack;
    dmem_if.resp    = resp;
    dmem_if.rdata   = rdata;
    @(negedge clk);
    full = (exp_q.size() == DEPTH);
    if (m_locked)                 g = m_held;
    else if (p[0].req && p[1].req) g = m_rr;
    else if (p[1].req)            g = 1'b1;
    else                          g = 1'b0;
    fwd = p[g].req && !full;
    chk("state", arb_state, m_locked ? ARB_HOLD : ARB_FREE);
    chk("busy", arb_busy, exp_q.size() != 0);
    chk("err", arb_err, m_err);
    chk("dmem_req", dmem_if.req, fwd);
    if (fwd) begin
      chk("dmem_addr", dmem_if.addr, p[g].addr);
      chk("dmem_wdata", dmem_if.wdata, p[g].wdata);
      chk("dmem_cmd", dmem_if.cmd, p[g].cmd);
      chk("dmem_width", dmem_if.width, p[g].width);
    end
    chk("lsu_ack", lsu_if.req_ack, fwd && ack && g == 1'b0);
    chk("vdma_ack", vdma_if.req_ack, fwd && ack && g == 1'b1);
    exp_resp[0] = SCR1_MEM_RESP_NOTRDY; exp_resp[1] = SCR1_MEM_RESP_NOTRDY;
    exp_rd[0] = '0; exp_rd[1] = '0;
    if (resp != SCR1_MEM_RESP_NOTRDY) begin
      if (exp_q.size() != 0) begin
        o = exp_q.pop_front();
        exp_resp[o] = resp;
        exp_rd[o]   = rdata;
      end else begin
        m_err = 1;
      end
    end
    chk("lsu_resp", lsu_if.resp, exp_resp[0]);
    chk("lsu_rdata", lsu_if.rdata, exp_rd[0]);
    chk("vdma_resp", vdma_if.resp, exp_resp[1]);
    chk("vdma_rdata", vdma_if.rdata, exp_rd[1]);
    if (fwd && ack) begin
      exp_q.push_back(g);
      m_rr     = ~g;
      m_locked = 0;
      p[g].req = 1'b0;
    end else if (fwd) begin
      m_locked = 1;
      m_held   = g;
    end
    @(posedge clk);
    #1;
  endtask

  task automatic drain();
    for (int k = 0; k < 8 && exp_q.size() != 0; k++) begin
      step(1'b0, SCR1_MEM_RESP_RDY_OK, {$urandom, $urandom});
    end
  endtask

  // ---------------- stimulus ----------------
  initial begin
    n_cmp  = 0;
    n_fail = 0;
    do_reset(2);

    // reset state: nothing requested, nothing outstanding
    step(1'b0, SCR1_MEM_RESP_NOTRDY, '0);

    // LSU load at 0x100, acked same cycle, RDY_OK the next
    set_req(0, SCR1_MEM_CMD_RD, SCR1_MEM_WIDTH_WORD, 32'h100, '0);
    step(1'b1, SCR1_MEM_RESP_NOTRDY, '0);
    step(1'b0, SCR1_MEM_RESP_RDY_OK, 64'hdead_beef_0000_0100);

    // simultaneous requests from a fresh reset: LSU first, then alternating
    do_reset(1);
    for (int k = 0; k < 6; k++) begin
      if (!p[0].req) set_req(0, SCR1_MEM_CMD_RD, SCR1_MEM_WIDTH_WORD, 32'h200 + k, '0);
      if (!p[1].req) set_req(1, SCR1_MEM_CMD_WR, SCR1_MEM_WIDTH_VECTOR, 32'h800 + k, {$urandom, $urandom});
      step(1'b1, (exp_q.size() != 0) ? SCR1_MEM_RESP_RDY_OK : SCR1_MEM_RESP_NOTRDY, {$urandom, $urandom});
    end
    p[0].req = 1'b0;
    p[1].req = 1'b0;
    drain();

    // VDMA vector store held off 3 cycles while LSU starts requesting
    set_req(1, SCR1_MEM_CMD_WR, SCR1_MEM_WIDTH_VECTOR, 32'h4000, 64'h0123_4567_89ab_cdef);
    step(1'b0, SCR1_MEM_RESP_NOTRDY, '0);
    set_req(0, SCR1_MEM_CMD_RD, SCR1_MEM_WIDTH_HWORD, 32'h104, '0);
    step(1'b0, SCR1_MEM_RESP_NOTRDY, '0);
    step(1'b0, SCR1_MEM_RESP_NOTRDY, '0);
    step(1'b1, SCR1_MEM_RESP_NOTRDY, '0);
    step(1'b1, SCR1_MEM_RESP_NOTRDY, '0);
    drain();

    // FIFO full: third request waits, not even forwarded in the popping cycle
    do_reset(1);
    set_req(0, SCR1_MEM_CMD_RD, SCR1_MEM_WIDTH_WORD, 32'h10, '0);
    step(1'b1, SCR1_MEM_RESP_NOTRDY, '0);
    set_req(1, SCR1_MEM_CMD_RD, SCR1_MEM_WIDTH_VECTOR, 32'h20, '0);
    step(1'b1, SCR1_MEM_RESP_NOTRDY, '0);
    set_req(0, SCR1_MEM_CMD_WR, SCR1_MEM_WIDTH_BYTE, 32'h30, 64'h55);
    step(1'b1, SCR1_MEM_RESP_NOTRDY, '0);
    step(1'b1, SCR1_MEM_RESP_RDY_OK, 64'h1111);
    step(1'b1, SCR1_MEM_RESP_NOTRDY, '0);
    drain();

    // RDY_ER for LSU then RDY_OK for VDMA, returned in issue order
    set_req(0, SCR1_MEM_CMD_RD, SCR1_MEM_WIDTH_WORD, 32'h40, '0);
    step(1'b1, SCR1_MEM_RESP_NOTRDY, '0);
    set_req(1, SCR1_MEM_CMD_RD, SCR1_MEM_WIDTH_VECTOR, 32'h50, '0);
    step(1'b1, SCR1_MEM_RESP_NOTRDY, '0);
    step(1'b0, SCR1_MEM_RESP_RDY_ER, 64'haaaa_0000_0000_0001);
    step(1'b0, SCR1_MEM_RESP_RDY_OK, 64'hbbbb_0000_0000_0002);

    // reset with a transaction pending; the late response becomes an orphan
    set_req(0, SCR1_MEM_CMD_RD, SCR1_MEM_WIDTH_WORD, 32'h60, '0);
    step(1'b1, SCR1_MEM_RESP_NOTRDY, '0);
    do_reset(1);
    step(1'b0, SCR1_MEM_RESP_RDY_OK, 64'hcccc);
    step(1'b0, SCR1_MEM_RESP_NOTRDY, '0);
    step(1'b0, SCR1_MEM_RESP_NOTRDY, '0);

    // random traffic
    do_reset(1);
    for (int k = 0; k < 400; k++) begin
      type_scr1_mem_resp_e r;
      for (int i = 0; i < 2; i++) begin
        if (!p[i].req && $urandom_range(0, 2) == 0) set_rand_req(i);
      end
      r = SCR1_MEM_RESP_NOTRDY;
      if (exp_q.size() != 0 && $urandom_range(0, 1) == 1) begin
        r = ($urandom_range(0, 3) == 0) ? SCR1_MEM_RESP_RDY_ER : SCR1_MEM_RESP_RDY_OK;
      end
      step($urandom_range(0, 3) != 0, r, {$urandom, $urandom});
    end

    // ---------------- report ----------------
    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_fail);
    $finish;
  end

endmodule : tb_scr1_dmem_arb
